// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory/mul-div freeze, load-use bubble, redirect flush.
// Optional perf counters (stall cycles, bubbles, flushes) are enabled with `define HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_req,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 md_valid,
  input  logic                 md_done,
  input  logic                 idex_mem_read,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  input  logic                 ifid_use_rs1,
  input  logic                 ifid_use_rs2,
  input  logic                 ex_redirect,
  output logic                 load_pc,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic [1:0]           stall_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]     perf_stall_cycles,
  output logic [CNT_W-1:0]     perf_bubbles,
  output logic [CNT_W-1:0]     perf_flushes
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_e;

  state_e state_q;
  logic   imem_done_q, imem_done_d;
  logic   dmem_done_q, dmem_done_d;

  logic i_pend, d_pend, mem_busy, md_busy, stall, load_use;

  assign i_pend   = imem_req & ~imem_resp & ~imem_done_q;
  assign d_pend   = dmem_req & ~dmem_resp & ~dmem_done_q;
  assign mem_busy = i_pend | d_pend;
  assign md_busy  = md_valid & ~md_done;
  assign stall    = mem_busy | md_busy;

  assign load_use = idex_mem_read & (idex_rd != '0) &
                    ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                     (ifid_use_rs2 & (ifid_rs2 == idex_rd)));

  // A response seen while the other side still stalls is remembered until the advance cycle.
  always_comb begin
    imem_done_d = imem_done_q;
    dmem_done_d = dmem_done_q;
    if (!stall) begin
      imem_done_d = 1'b0;
      dmem_done_d = 1'b0;
    end else begin
      if (imem_resp) imem_done_d = 1'b1;
      if (dmem_resp) dmem_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      imem_done_q <= 1'b0;
      dmem_done_q <= 1'b0;
    end else begin
      imem_done_q <= imem_done_d;
      dmem_done_q <= dmem_done_d;
      if (mem_busy)     state_q <= MEM_WAIT;
      else if (md_busy) state_q <= MD_WAIT;
      else              state_q <= RUN;
    end
  end

  assign stall_state = state_q;

  always_comb begin
    load_pc     = 1'b1;
    load_if_id  = 1'b1;
    load_id_ex  = 1'b1;
    load_ex_mem = 1'b1;
    load_mem_wb = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst || stall) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
    end else if (ex_redirect) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      flush_id_ex = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (stall)                              stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (!stall && ex_redirect)              flush_cnt_q  <= flush_cnt_q + 1'b1;
      if (!stall && !ex_redirect && load_use) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_bubbles      = bubble_cnt_q;
  assign perf_flushes      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst;
  logic imem_req, imem_resp, dmem_req, dmem_resp, md_valid, md_done;
  logic idex_mem_read, ifid_use_rs1, ifid_use_rs2, ex_redirect;
  logic [RW-1:0] idex_rd, ifid_rs1, ifid_rs2;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex;
  logic [1:0] stall_state;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] perf_stall_cycles, perf_bubbles, perf_flushes;
  int unsigned m_nstall, m_nbub, m_nflush;
`endif

  pipeline_hazard_ctrl #(.REG_IDX_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .md_valid(md_valid), .md_done(md_done),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .ex_redirect(ex_redirect),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_state(stall_state)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_bubbles(perf_bubbles),
    .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: "has this side already answered" memory and the reported wait reason.
  bit m_i_answered, m_d_answered;
  int m_state;

  function automatic logic [6:0] dut_ctl();
    return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex};
  endfunction

  task automatic model_reset();
    m_i_answered = 0;
    m_d_answered = 0;
    m_state      = 0;
`ifdef HAZARD_PERF_EN
    m_nstall = 0; m_nbub = 0; m_nflush = 0;
`endif
  endtask

  task automatic step();
    bit waiting_i, waiting_d, waiting_md, frozen, hazard;
    logic [6:0] exp;
    #1;
    waiting_i  = imem_req && !imem_resp && !m_i_answered;
    waiting_d  = dmem_req && !dmem_resp && !m_d_answered;
    waiting_md = md_valid && !md_done;
    frozen     = waiting_i || waiting_d || waiting_md;
    hazard     = idex_mem_read && (idex_rd != 0) &&
                 ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
    if (frozen)           exp = 7'b00000_00;
    else if (ex_redirect) exp = 7'b11111_11;
    else if (hazard)      exp = 7'b00111_01;
    else                  exp = 7'b11111_00;
    check_eq("ctl", 32'(dut_ctl()), 32'(exp));
    check_eq("state", 32'(stall_state), 32'(m_state));
`ifdef HAZARD_PERF_EN
    check_eq("perf_stall", perf_stall_cycles, m_nstall);
    check_eq("perf_bub", perf_bubbles, m_nbub);
    check_eq("perf_flush", perf_flushes, m_nflush);
`endif
    @(posedge clk);
    if (!frozen) begin
      m_i_answered = 0;
      m_d_answered = 0;
    end else begin
      if (imem_resp) m_i_answered = 1;
      if (dmem_resp) m_d_answered = 1;
    end
    m_state = (waiting_i || waiting_d) ? 1 : (waiting_md ? 2 : 0);
`ifdef HAZARD_PERF_EN
    if (frozen) m_nstall++;
    else if (ex_redirect) m_nflush++;
    else if (hazard) m_nbub++;
`endif
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    md_valid = 0; md_done = 0; idex_mem_read = 0; idex_rd = '0;
    ifid_rs1 = '0; ifid_rs2 = '0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    ex_redirect = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    check_eq("rst_ctl", 32'(dut_ctl()), 32'd0);
    check_eq("rst_state", 32'(stall_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch wait of three cycles, response on the fourth.
    for (int c = 0; c < 5; c++) begin
      imem_req = (c <= 3); imem_resp = (c == 3);
      step();
    end
    idle_inputs();

    // Both sides outstanding: I answers early, D late.
    for (int c = 0; c < 6; c++) begin
      imem_req = (c <= 4); dmem_req = (c <= 4);
      imem_resp = (c == 1); dmem_resp = (c == 4);
      step();
    end
    idle_inputs();

    // Load-use on rs2, then rd=0 (no bubble), then redirect overriding it.
    idex_mem_read = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
    step();
    idex_rd = 0; ifid_rs2 = 0;
    step();
    idex_rd = 5; ifid_rs2 = 5; ex_redirect = 1;
    step();
    idle_inputs();

    // Long mul/div with a data-side stall in the middle.
    for (int c = 0; c <= 33; c++) begin
      md_valid = (c <= 32); md_done = (c == 32);
      dmem_req = (c >= 10 && c <= 12); dmem_resp = (c == 12);
      step();
    end
    idle_inputs();

    // Async reset mid MEM_WAIT with the data-side answer remembered.
    imem_req = 1; dmem_req = 1; dmem_resp = 1;
    step();
    dmem_resp = 0;
    step();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ctl", 32'(dut_ctl()), 32'd0);
    check_eq("arst_state", 32'(stall_state), 32'd0);
`ifdef HAZARD_PERF_EN
    check_eq("arst_perf", perf_stall_cycles | perf_bubbles | perf_flushes, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    imem_req = 0;
    step();
    idle_inputs();

    // Random traffic; small register range keeps load-use frequent.
    for (int n = 0; n < 3000; n++) begin
      imem_req      = ($urandom_range(0, 9) < 4);
      imem_resp     = ($urandom_range(0, 9) < 3);
      dmem_req      = ($urandom_range(0, 9) < 3);
      dmem_resp     = ($urandom_range(0, 9) < 3);
      md_valid      = ($urandom_range(0, 9) < 2);
      md_done       = ($urandom_range(0, 9) < 3);
      idex_mem_read = ($urandom_range(0, 9) < 6);
      idex_rd       = RW'($urandom_range(0, 3));
      ifid_rs1      = RW'($urandom_range(0, 3));
      ifid_rs2      = RW'($urandom_range(0, 3));
      ifid_use_rs1  = 1'($urandom_range(0, 1));
      ifid_use_rs2  = 1'($urandom_range(0, 1));
      ex_redirect   = ($urandom_range(0, 9) < 2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the load enables of PC, IF_ID, ID_EX, EX_MEM and MEM_WB, and the bubble/flush controls of IF_ID and ID_EX.
- Freezes the pipeline on outstanding I/D memory responses and on multi-cycle mul/div.
- Inserts a bubble on load-use hazards and flushes younger stages on EX-stage redirects.

Parameters:
- REG_IDX_W, 5, register index width.
- CNT_W, 32, perf counter width; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- imem_req  in  1  fetch outstanding for the current IF instruction
- imem_resp  in  1  I-side response, single-cycle pulse
- dmem_req  in  1  MEM-stage load/store outstanding
- dmem_resp  in  1  D-side response, single-cycle pulse
- md_valid  in  1  EX stage holds a mul/div op
- md_done  in  1  mul/div result ready, single-cycle pulse
- idex_mem_read  in  1  ID_EX instruction is a load
- idex_rd  in  REG_IDX_W  ID_EX destination register
- ifid_rs1  in  REG_IDX_W  IF_ID source 1
- ifid_rs2  in  REG_IDX_W  IF_ID source 2
- ifid_use_rs1  in  1  IF_ID reads rs1
- ifid_use_rs2  in  1  IF_ID reads rs2
- ex_redirect  in  1  EX branch taken / jump (PC redirect)
- load_pc  out  1  PC register enable
- load_if_id  out  1  IF_ID register enable
- load_id_ex  out  1  ID_EX register enable
- load_ex_mem  out  1  EX_MEM register enable
- load_mem_wb  out  1  MEM_WB register enable
- flush_if_id  out  1  IF_ID loads NOP control word
- flush_id_ex  out  1  ID_EX loads NOP control word
- stall_state  out  2  0=RUN, 1=MEM_WAIT, 2=MD_WAIT

Behaviour:
- State register: RUN / MEM_WAIT / MD_WAIT. Sticky flags: imem_done_q, dmem_done_q.
- On rst (async), state=RUN and both sticky flags are cleared.
- While rst is high, all load_* = 0, flush_* = 0, stall_state = 0.
- Internal terms:
  - i_pend = imem_req & ~imem_resp & ~imem_done_q
  - d_pend = dmem_req & ~dmem_resp & ~dmem_done_q
  - mem_busy = i_pend | d_pend
  - md_busy = md_valid & ~md_done
  - stall = mem_busy | md_busy
- Sticky flags:
  - imem_done_q is set when imem_resp=1 and stall=1 (the other side is still pending).
  - dmem_done_q is set symmetrically.
  - Both flags clear on any cycle with stall=0 (advance cycle).
  - A response never needs to be re-sent.
- Outputs are combinational from the current state, flags and inputs (zero-latency enables).
- Priority, highest first:
  1. stall=1: every load_* = 0, flush_* = 0. The whole pipeline is frozen, including MEM_WB.
  2. ex_redirect=1: every load_* = 1, flush_if_id = 1, flush_id_ex = 1. The PC takes the redirect target.
  3. Load-use hazard, defined as idex_mem_read & idex_rd≠0 & ((ifid_use_rs1 & ifid_rs1==idex_rd) | (ifid_use_rs2 & ifid_rs2==idex_rd)):
     - load_pc = 0, load_if_id = 0, load_id_ex = 1, flush_id_ex = 1 (bubble).
     - load_ex_mem = 1, load_mem_wb = 1.
  4. Otherwise: every load_* = 1, flush_* = 0.
- Redirect overrides load-use in the same cycle; the hazarded instruction is squashed anyway.
- A redirect arriving during a stall is deferred automatically, because EX is frozen and holds ex_redirect. It is applied on the advance cycle.
- Rd index 0 never triggers load-use.
- FSM transitions, evaluated each clk:
  - RUN → MEM_WAIT if mem_busy.
  - RUN → MD_WAIT if md_busy & ~mem_busy.
  - MEM_WAIT → MD_WAIT if ~mem_busy & md_busy.
  - MEM_WAIT → RUN if ~stall.
  - MD_WAIT → MEM_WAIT if mem_busy.
  - MD_WAIT → RUN if ~stall.
  - mem_busy has priority in encoding.
- stall_state reports the registered state. It is informational; enables never depend on it.
- A response pulse in the same cycle the request first asserts counts as zero-wait: no stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, add outputs perf_stall_cycles [CNT_W], perf_bubbles [CNT_W] and perf_flushes [CNT_W].
  - perf_stall_cycles increments on each cycle with stall=1.
  - perf_bubbles increments on each load-use bubble.
  - perf_flushes increments on each applied redirect.
  - All three reset to 0 asynchronously and wrap at 2^CNT_W.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- imem_req=1, imem_resp arrives 3 cycles later; dmem idle → all loads = 0 for 3 cycles, stall_state=1 for 3 cycles, then all loads = 1 and state returns to 0.
- imem_req and dmem_req both asserted; imem_resp at cycle 1, dmem_resp at cycle 4 → imem_done_q set at cycle 1; frozen through cycle 3; advance at cycle 4; flags cleared at cycle 5.
- idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1 → load_pc = load_if_id = 0, flush_id_ex = 1, load_ex_mem = 1 for exactly one cycle. The same case with idex_rd=0 produces no bubble.
- ex_redirect=1 together with the load-use condition above → flush_if_id = flush_id_ex = 1 and all loads = 1 (redirect wins).
- md_valid=1, md_done after 32 cycles, with a dmem stall starting at cycle 10 for 2 cycles → state sequence MD_WAIT → MEM_WAIT → MD_WAIT → RUN; loads = 0 throughout.
- rst asserted mid MEM_WAIT with dmem_done_q=1 → state=0, flags cleared and all outputs 0 immediately (async). With HAZARD_PERF_EN defined, the counters also read 0.
